// File: rtl/multicycle_controller.sv
// Multi-cycle sequencing FSM for the 16-bit compressed-instruction datapath.
// Steps fetch/decode/exec/mem/writeback with wait handshakes, timeouts and a retire counter.
module multicycle_controller #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [3:0]       opcode,
  input  logic             branch_cond,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_write,
  output logic             alu_en,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             pc_write,
  output logic             pc_src,
  output logic             halted,
  output logic [1:0]       fault,
  output logic [CNT_W-1:0] retired_count
);

  localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = (TIMEOUT > 0) ? WAIT_W'(TIMEOUT - 1) : '0;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b01;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    K_LOAD, K_STORE, K_ALU, K_BRANCH, K_ILLEGAL
  } op_class_t;

  state_t            state, state_next;
  op_class_t         op_class;
  logic [1:0]        fault_q, fault_next;
  logic [CNT_W-1:0]  count_q;
  logic [WAIT_W-1:0] wait_cnt, wait_next;
  logic              retire;
  logic              wait_expired;

  always_comb begin
    if (opcode == 4'd0)       op_class = K_LOAD;
    else if (opcode == 4'd1)  op_class = K_STORE;
    else if (opcode <= 4'd9)  op_class = K_ALU;
    else if (opcode <= 4'd11) op_class = K_BRANCH;
    else                      op_class = K_ILLEGAL;
  end

  // Ready on the last allowed cycle still wins over the timeout.
  assign wait_expired = (TIMEOUT != 0) && (wait_cnt == WAIT_LAST);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_next = state;
    fault_next = fault_q;
    retire     = 1'b0;
    imem_req   = 1'b0;
    ir_write   = 1'b0;
    alu_en     = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    halted     = 1'b0;

    case (state)
      S_IDLE: if (run) state_next = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write   = 1'b1;
          state_next = S_DECODE;
        end else if (wait_expired) begin
          state_next = S_HALT;
          fault_next = FAULT_TIMEOUT;
        end
      end
      S_DECODE: begin
        if (op_class == K_ILLEGAL) begin
          state_next = S_HALT;
          fault_next = FAULT_ILLEGAL;
        end else begin
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_en = 1'b1;
        case (op_class)
          K_ALU:           state_next = S_WB;
          K_LOAD, K_STORE: state_next = S_MEM;
          K_BRANCH: begin
            pc_write = 1'b1;
            pc_src   = branch_cond;
            retire   = 1'b1;
          end
          default:         state_next = S_HALT;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (op_class == K_STORE);
        if (dmem_ready) begin
          if (op_class == K_STORE) begin
            pc_write = 1'b1;
            retire   = 1'b1;
          end else begin
            state_next = S_WB;
          end
        end else if (wait_expired) begin
          state_next = S_HALT;
          fault_next = FAULT_TIMEOUT;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (op_class == K_LOAD);
        pc_write   = 1'b1;
        retire     = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      default: state_next = S_IDLE;
    endcase

    // Retire goes straight to the next fetch so back-to-back issue has no bubble.
    if (retire) state_next = run ? S_FETCH : S_IDLE;

    wait_next = ((state_next == state) && ((state == S_FETCH) || (state == S_MEM)))
              ? wait_cnt + 1'b1 : '0;

    // Requests must drop in the very cycle reset rises, before the edge samples it.
    if (rst) begin
      imem_req   = 1'b0;
      ir_write   = 1'b0;
      alu_en     = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      halted     = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      fault_q  <= FAULT_NONE;
      count_q  <= '0;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      fault_q  <= fault_next;
      wait_cnt <= wait_next;
      if (retire) count_q <= count_q + 1'b1;
    end
  end

  assign fault         = rst ? FAULT_NONE : fault_q;
  assign retired_count = rst ? '0 : count_q;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle sequencing FSM for the 16-bit compressed-instruction datapath.
- Steps each instruction through fetch, decode, execute, memory and writeback.
- Issues per-phase enables (IR load, ALU, memory request, register write, PC update) around the static controls the instruction decoder produces.
- Handles instruction/data memory wait handshakes, memory-timeout faults, illegal opcodes and a retired-instruction counter.

Parameters:
- CNT_W, 16, width of retired_count (wraps modulo 2^CNT_W).
- TIMEOUT, 16, max cycles a memory request is held without ready before faulting; 0 disables timeout. Wait counter width is $clog2(TIMEOUT+1), minimum 1.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- run  input  1  level; 1 = keep issuing instructions
- opcode  input  4  opcode field of the instruction register, valid from DECODE onward
- branch_cond  input  1  ALU branch-condition result, sampled in EXEC
- imem_ready  input  1  instruction memory data valid
- dmem_ready  input  1  data memory access complete
- imem_req  output  1  instruction fetch request
- ir_write  output  1  load instruction register
- alu_en  output  1  ALU operand/result latch enable
- dmem_req  output  1  data memory request
- dmem_we  output  1  data memory write (valid only with dmem_req)
- reg_write  output  1  register file write strobe
- mem_to_reg  output  1  writeback source: 1 = memory, 0 = ALU
- pc_write  output  1  PC update strobe
- pc_src  output  1  0 = PC+2, 1 = branch target
- halted  output  1  controller in HALT
- fault  output  2  00 none, 01 memory timeout, 10 illegal opcode
- retired_count  output  CNT_W  instructions retired since reset

Behaviour:
- All outputs are combinational decodes of the state register plus the listed inputs. fault and retired_count are registered.
- While rst=1, every output is 0. On the first edge with rst=1: state←IDLE, fault←00, retired_count←0, wait counter←0. Reset in any state, including mid-MEM or HALT, takes effect on that edge; requests drop in the same cycle rst rises.
- Opcode classes:
  - 0000 load
  - 0001 store
  - 0010–1001 ALU
  - 1010/1011 branch
  - 1100–1111 illegal
- IDLE: all enables 0. run=1 → FETCH.
- FETCH:
  - imem_req=1.
  - imem_ready=1: ir_write=1 in that cycle, → DECODE.
  - Otherwise stay and increment the wait counter.
- DECODE: single cycle, no enables. Illegal class → HALT with fault←10. Otherwise → EXEC.
- EXEC: alu_en=1.
  - ALU → WB.
  - Load or store → MEM.
  - Branch: pc_write=1, pc_src=branch_cond, retire.
- MEM:
  - dmem_req=1; dmem_we=1 for store, 0 for load.
  - dmem_ready=1 and store: pc_write=1, pc_src=0, retire.
  - dmem_ready=1 and load: → WB.
  - Otherwise stay and increment the wait counter.
- WB: reg_write=1, mem_to_reg=1 for load and 0 for ALU, pc_write=1, pc_src=0, retire.
- Retire: retired_count increments on the same edge. Next state is FETCH if run=1 in that cycle, else IDLE.
- run only gates instruction issue. Deasserting run mid-instruction lets that instruction complete.
- Timeout:
  - The wait counter clears on entry to FETCH/MEM.
  - With TIMEOUT>0, a request is held at most TIMEOUT cycles; ready on cycle TIMEOUT is accepted.
  - If ready is low on cycle TIMEOUT, the next state is HALT with fault←01.
- HALT: halted=1, all other enables 0, fault held. Exit only via rst.
- Latency with zero-wait memory, first request cycle to retire edge inclusive:
  - ALU 4 cycles
  - store 4 cycles
  - load 5 cycles
  - branch 3 cycles
- Back-to-back instructions have no bubble: FETCH follows the retire cycle directly.

Test Plan:
- ALU 0100 back-to-back, run=1, imem_ready=1 → imem_req/ir_write, DECODE, alu_en, then reg_write+pc_write with pc_src=0; repeats every 4 cycles; retired_count 0→1→2.
- Load 0000 with dmem_ready low for 3 MEM cycles → dmem_req=1, dmem_we=0 for 4 cycles, then WB with reg_write=1, mem_to_reg=1; retired_count +1. Store 0001: dmem_we=1, no reg_write.
- Branch 1010: branch_cond=1 → EXEC shows pc_write=1, pc_src=1. Repeat with branch_cond=0 → pc_src=0. Each retires in 3 cycles.
- Opcode 1100 fetched → HALT after DECODE, halted=1, fault=10, no pc_write/reg_write. Stays halted with run=1 until rst.
- TIMEOUT=4, imem_ready held 0 → imem_req for exactly 4 cycles, then halted=1, fault=01. Second run with ready on cycle 4 → accepted, no fault.
- rst asserted during MEM wait, then run deasserted mid-ALU instruction → rst: dmem_req drops that cycle, state IDLE, retired_count=0. run low: instruction completes WB, then IDLE, no further imem_req.
